// File: rtl/hw_cmd_executor.sv
// Command executor for the software PIO: detects toggle-marked command words, queues them,
// and replays them as valid/ready register writes while exporting a status word.
//
// state | meaning
// IDLE  | waiting for a queued command; pops one when the queue is non-empty
// EXEC  | one-cycle decode of the popped command; non-write commands complete here
// WRITE | single write held on the bus until accepted
// FILL  | burst of fill_len writes of the same data to incrementing addresses
module hw_cmd_executor #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       cmd_word,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [11:0]       wr_data,
  output logic [15:0]       status_word
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, EXEC, WRITE, FILL} state_t;

  state_t            state, state_nx;
  logic [14:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              prev_toggle;
  logic [14:0]       cmd_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [11:0]       fill_len;
  logic [11:0]       remaining;
  logic              last_toggle;
  logic              overflow;
  logic              illegal;
  logic [7:0]        done_cnt;

  logic              push_req, push_ok, pop, fifo_full, fifo_empty;
  logic              complete, accept, in_exec;
  logic [2:0]        opcode;
  logic [11:0]       operand;
  logic [4:0]        cnt_ext;
  logic [3:0]        cnt_field;

  assign opcode     = cmd_reg[14:12];
  assign operand    = cmd_reg[11:0];
  assign fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign push_req   = cmd_word[15] ^ prev_toggle;
  // Fullness is judged before any same-cycle pop, so a push into a full queue always drops.
  assign push_ok    = push_req && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign in_exec    = (state == EXEC);
  assign accept     = wr_valid && wr_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    complete = 1'b0;
    wr_valid = 1'b0;
    case (state)
      IDLE: if (!fifo_empty) state_nx = EXEC;
      EXEC: begin
        case (opcode)
          3'd2: state_nx = WRITE;
          3'd3: begin
            if (fill_len == '0) begin
              complete = 1'b1;
              state_nx = IDLE;
            end else begin
              state_nx = FILL;
            end
          end
          default: begin
            complete = 1'b1;
            state_nx = IDLE;
          end
        endcase
      end
      WRITE: begin
        wr_valid = 1'b1;
        if (wr_ready) begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      FILL: begin
        wr_valid = 1'b1;
        if (wr_ready && remaining == 12'd1) begin
          complete = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= cmd_word[14:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_toggle <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      last_toggle <= 1'b0;
    end else begin
      prev_toggle <= cmd_word[15];
      if (push_ok) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        last_toggle <= cmd_word[15];
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_reg   <= '0;
      addr_reg  <= '0;
      fill_len  <= '0;
      remaining <= '0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      done_cnt  <= '0;
    end else begin
      if (pop) cmd_reg <= fifo_mem[rd_ptr];
      if (in_exec && opcode == 3'd1)  addr_reg <= operand[ADDR_W-1:0];
      else if (accept)                addr_reg <= addr_reg + ADDR_W'(1);
      if (in_exec && opcode == 3'd4)  fill_len <= operand;
      if (in_exec && opcode == 3'd3)  remaining <= fill_len;
      else if (accept && state == FILL) remaining <= remaining - 12'd1;
      // A drop in the same cycle as CLR_STATUS still leaves overflow set.
      if (in_exec && opcode == 3'd5) begin
        overflow <= 1'b0;
        illegal  <= 1'b0;
      end
      if (push_req && fifo_full)                illegal <= illegal;
      if (push_req && fifo_full)                overflow <= 1'b1;
      if (in_exec && opcode[2:1] == 2'b11)      illegal  <= 1'b1;
      if (complete) done_cnt <= done_cnt + 8'd1;
    end
  end

  assign cnt_ext     = 5'(fifo_cnt);
  assign cnt_field   = cnt_ext[4] ? 4'hF : cnt_ext[3:0];
  assign wr_addr     = addr_reg;
  assign wr_data     = operand;
  assign status_word = {last_toggle, (!fifo_empty || state != IDLE), overflow, illegal,
                        cnt_field, done_cnt};

endmodule
